// File: rtl/ins_loader_if.sv
// rtl/ins_loader_if.sv - program load stream, pc read port and status signals of the instruction loader
interface ins_loader_if;
  logic       load_req;
  logic       in_valid;
  logic [8:0] IN_INS;
  logic       in_last;
  logic       in_ready;
  logic [3:0] PC;
  logic [8:0] RES_INS;
  logic       set_pc;
  logic [3:0] LOAD_ADDR;
  logic       prog_valid;

  modport slave (
    input  load_req, in_valid, IN_INS, in_last, PC,
    output in_ready, RES_INS, set_pc, LOAD_ADDR, prog_valid
  );

  modport master (
    output load_req, in_valid, IN_INS, in_last, PC,
    input  in_ready, RES_INS, set_pc, LOAD_ADDR, prog_valid
  );
endinterface

// File: rtl/ins_loader.sv
// rtl/ins_loader.sv - 16x9 program memory loaded from a word stream, padded with FILL_INS, read by pc
module ins_loader #(
  parameter logic [8:0] FILL_INS = 9'b000000000
) (
  input logic         clk,
  input logic         rst,
  ins_loader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, FILL, RUN} state_t;

  state_t     state;
  state_t     state_next;
  logic [8:0] mem [16];
  logic [3:0] addr;
  logic [3:0] addr_next;
  logic       pv;
  logic       pv_next;
  logic       we;
  logic [8:0] wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr  <= 4'd0;
      pv    <= 1'b0;
    end else begin
      state <= state_next;
      addr  <= addr_next;
      pv    <= pv_next;
    end
  end

  // Memory has no reset so a program survives rst; writes are still blocked during rst.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      mem[addr] <= wdata;
    end
  end

  always_comb begin
    state_next = state;
    addr_next  = addr;
    pv_next    = pv;
    we         = 1'b0;
    wdata      = FILL_INS;
    case (state)
      IDLE: begin
        if (bus.load_req) begin
          state_next = LOAD;
          addr_next  = 4'd0;
          pv_next    = 1'b0;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          we        = 1'b1;
          wdata     = bus.IN_INS;
          addr_next = addr + 4'd1;
          if (addr == 4'd15) begin
            state_next = RUN;
            pv_next    = 1'b1;
          end else if (bus.in_last) begin
            state_next = FILL;
          end
        end
      end
      FILL: begin
        we        = 1'b1;
        addr_next = addr + 4'd1;
        if (addr == 4'd15) begin
          state_next = RUN;
          pv_next    = 1'b1;
        end
      end
      RUN: begin
        if (bus.load_req) begin
          state_next = LOAD;
          addr_next  = 4'd0;
          pv_next    = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready   = (state == LOAD);
  assign bus.set_pc     = (state != RUN);
  assign bus.RES_INS    = (state == RUN) ? mem[bus.PC] : FILL_INS;
  assign bus.LOAD_ADDR  = addr;
  assign bus.prog_valid = pv;

endmodule

// File: tb/tb_ins_loader.sv
// tb/tb_ins_loader.sv - randomized directed bench for ins_loader against a program-image model
module tb_ins_loader;

  localparam logic [8:0] FILL = 9'h1EE;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ins_loader_if bus ();

  ins_loader #(.FILL_INS(FILL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Expected program image: the words of a load, then FILL up to entry 15.
  logic [8:0] words     [16];
  int         gaps      [16];
  logic [8:0] model_mem [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_outputs(input string tag, input bit rdy, input bit setpc,
                                input bit pv, input int addr, input bit chk_res);
    chk({tag, ".in_ready"},   32'(bus.in_ready),   32'(rdy));
    chk({tag, ".set_pc"},     32'(bus.set_pc),     32'(setpc));
    chk({tag, ".prog_valid"}, 32'(bus.prog_valid), 32'(pv));
    chk({tag, ".LOAD_ADDR"},  32'(bus.LOAD_ADDR),  32'(addr));
    if (chk_res) chk({tag, ".RES_INS"}, 32'(bus.RES_INS), 32'(FILL));
  endtask

  task automatic clear_inputs();
    bus.load_req = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.IN_INS   = 9'h000;
  endtask

  // Loads words[0..n-1] with gaps[i] idle cycles before word i; resets when the fill reaches abort_at.
  task automatic do_load(input int n, input int abort_at);
    bus.load_req = 1'b1;
    bus.PC       = 4'($urandom);
    tick();
    bus.load_req = 1'b0;
    expect_outputs("load_entry", 1, 1, 0, 0, 1);
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.IN_INS   = 9'($urandom);
        bus.load_req = 1'($urandom);
        tick();
        expect_outputs("load_gap", 1, 1, 0, i, 1);
      end
      bus.in_valid = 1'b1;
      bus.IN_INS   = words[i];
      bus.in_last  = (i == n - 1);
      bus.load_req = (i == n - 1) ? 1'b1 : 1'($urandom);
      chk("accept_ready", 32'(bus.in_ready), 32'd1);
      tick();
      model_mem[i] = words[i];
      if (i < n - 1) expect_outputs("load_acc", 1, 1, 0, i + 1, 1);
    end
    for (int j = 0; j < 16 - n; j++) begin
      bus.in_valid = 1'($urandom);
      bus.in_last  = 1'($urandom);
      bus.IN_INS   = 9'($urandom);
      bus.load_req = 1'($urandom);
      expect_outputs("fill", 0, 1, 0, n + j, 1);
      if (abort_at == n + j) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        expect_outputs("rst_fill", 0, 1, 0, 0, 1);
        return;
      end
      tick();
      model_mem[n + j] = FILL;
    end
    clear_inputs();
    expect_outputs("run", 0, 0, 1, 0, 0);
    for (int p = 0; p < 16; p++) begin
      bus.PC = 4'(p);
      #1;
      chk($sformatf("read[%0d]", p), 32'(bus.RES_INS), 32'(model_mem[p]));
      tick();
    end
    expect_outputs("run_hold", 0, 0, 1, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    bus.PC = 4'd0;
    for (int i = 0; i < 16; i++) model_mem[i] = FILL;
    tick();
    tick();
    expect_outputs("reset", 0, 1, 0, 0, 1);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    expect_outputs("idle_hold", 0, 1, 0, 0, 1);

    // full back-to-back program 9'h100+i
    for (int i = 0; i < 16; i++) begin
      words[i] = 9'h100 + 9'(i);
      gaps[i]  = 0;
    end
    do_load(16, -1);

    // three words then 13 fill cycles, reloaded from RUN
    words[0] = 9'h1A1;
    words[1] = 9'h0F2;
    words[2] = 9'h133;
    do_load(3, -1);

    // in_valid pattern 1,0,0,1
    words[0] = 9'($urandom);
    words[1] = 9'($urandom);
    gaps[1]  = 2;
    do_load(2, -1);
    gaps[1]  = 0;

    // reset while filling entry 7
    for (int i = 0; i < 3; i++) words[i] = 9'($urandom);
    do_load(3, 7);
    tick();
    expect_outputs("idle_after_rst", 0, 1, 0, 0, 1);

    // full random load, then single-word reload from RUN
    for (int i = 0; i < 16; i++) words[i] = 9'($urandom);
    do_load(16, -1);
    words[0] = 9'h055;
    do_load(1, -1);

    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 16);
      for (int i = 0; i < 16; i++) begin
        words[i] = 9'($urandom);
        gaps[i]  = $urandom_range(0, 2);
      end
      do_load(n, -1);
    end

    // reset in RUN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_outputs("rst_run", 0, 1, 0, 0, 1);

    // reset mid-LOAD with a word presented
    bus.load_req = 1'b1;
    tick();
    bus.load_req = 1'b0;
    bus.in_valid = 1'b1;
    bus.IN_INS   = 9'h0AA;
    tick();
    expect_outputs("mid_load", 1, 1, 0, 1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_inputs();
    expect_outputs("rst_load", 0, 1, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
